// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types for the pipeline hazard controller
package hazard_ctrl_pkg;

    typedef logic [63:0] u64;
    typedef logic [4:0]  creg_addr_t;

    typedef enum logic [0:0] {
        F_RUN  = 1'b0,
        F_KILL = 1'b1
    } fstate_t;

    // Per-stage stall/flush controls, handed to the core as one bundle
    typedef struct packed {
        logic stallF;
        logic stallD;
        logic stallE;
        logic stallM;
        logic flushD;
        logic flushE;
        logic flushW;
    } hazard_ctl_t;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// rtl/hazard_ctrl_detect.sv - load-use and branch-on-load register comparators
import hazard_ctrl_pkg::*;

module hazard_detect (
    input  logic       memreadE,
    input  logic       memreadM,
    input  logic       branchD,
    input  creg_addr_t dstE,
    input  creg_addr_t dstM,
    input  creg_addr_t ra1D,
    input  creg_addr_t ra2D,
    output logic       lu,
    output logic       bl
);

    // x0 is never a real dependency
    assign lu = memreadE && (dstE != 5'd0) && ((dstE == ra1D) || (dstE == ra2D));
    assign bl = branchD && memreadM && (dstM != 5'd0) && ((dstM == ra1D) || (dstM == ra2D));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - five-stage pipeline stall/flush/redirect controller
import hazard_ctrl_pkg::*;

module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_req,
    input  logic       i_data_ok,
    input  logic       d_req,
    input  logic       d_data_ok,
    input  logic       jumpD,
    input  u64         pcsrcD,
    input  logic       branchD,
    input  creg_addr_t ra1D,
    input  creg_addr_t ra2D,
    input  logic       memreadE,
    input  logic       memreadM,
    input  creg_addr_t dstE,
    input  creg_addr_t dstM,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushD,
    output logic       flushE,
    output logic       flushW,
    output logic       redirect_valid,
    output u64         redirect_pc
);

    fstate_t     fstate_q, fstate_d;
    u64          target_q, target_d;
    hazard_ctl_t ctl;
    logic        redir;
    logic        lu, bl, dwait, iwait, take;

    hazard_detect u_detect (
        .memreadE (memreadE),
        .memreadM (memreadM),
        .branchD  (branchD),
        .dstE     (dstE),
        .dstM     (dstM),
        .ra1D     (ra1D),
        .ra2D     (ra2D),
        .lu       (lu),
        .bl       (bl)
    );

    assign dwait = d_req && !d_data_ok;
    assign iwait = i_req && !i_data_ok;
    // A jump resolved on stale operands must not redirect
    assign take  = jumpD && !dwait && !lu && !bl;

    always_comb begin
        ctl      = '0;
        redir    = 1'b0;
        fstate_d = fstate_q;
        target_d = target_q;

        if (dwait) begin
            ctl.stallF = 1'b1;
            ctl.stallD = 1'b1;
            ctl.stallE = 1'b1;
            ctl.stallM = 1'b1;
            ctl.flushW = 1'b1;
        end else if (lu || bl) begin
            ctl.stallF = 1'b1;
            ctl.stallD = 1'b1;
            ctl.flushE = 1'b1;
        end else if (fstate_q == F_RUN) begin
            if (take && !iwait) begin
                redir      = 1'b1;
                ctl.flushD = 1'b1;
            end else if (take) begin
                target_d   = pcsrcD;
                fstate_d   = F_KILL;
                ctl.flushD = 1'b1;
                ctl.stallF = 1'b1;
            end else if (iwait) begin
                ctl.stallF = 1'b1;
                ctl.flushD = 1'b1;
            end
        end

        // Wrong-path fetch drains independently of D-M stalls
        if (fstate_q == F_KILL) begin
            ctl.flushD = 1'b1;
            ctl.stallF = 1'b1;
            if (i_data_ok) begin
                redir    = 1'b1;
                fstate_d = F_RUN;
            end
        end

        if (!reset) begin
            ctl        = '0;
            ctl.flushD = 1'b1;
            ctl.flushE = 1'b1;
            ctl.flushW = 1'b1;
            redir      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fstate_q <= F_RUN;
            target_q <= '0;
        end else begin
            fstate_q <= fstate_d;
            target_q <= target_d;
        end
    end

    assign stallF         = ctl.stallF;
    assign stallD         = ctl.stallD;
    assign stallE         = ctl.stallE;
    assign stallM         = ctl.stallM;
    assign flushD         = ctl.flushD;
    assign flushE         = ctl.flushE;
    assign flushW         = ctl.flushW;
    assign redirect_valid = redir;
    assign redirect_pc    = (fstate_q == F_KILL) ? target_q : pcsrcD;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
`timescale 1ns/1ps

module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_data_ok, d_req, d_data_ok, jumpD, branchD;
    logic [63:0] pcsrcD;
    logic [4:0]  ra1D, ra2D, dstE, dstM;
    logic        memreadE, memreadM;
    logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW, redirect_valid;
    logic [63:0] redirect_pc;

    int n_total = 0;
    int n_pass  = 0;

    hazard_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .i_req          (i_req),
        .i_data_ok      (i_data_ok),
        .d_req          (d_req),
        .d_data_ok      (d_data_ok),
        .jumpD          (jumpD),
        .pcsrcD         (pcsrcD),
        .branchD        (branchD),
        .ra1D           (ra1D),
        .ra2D           (ra2D),
        .memreadE       (memreadE),
        .memreadM       (memreadM),
        .dstE           (dstE),
        .dstM           (dstM),
        .stallF         (stallF),
        .stallD         (stallD),
        .stallE         (stallE),
        .stallM         (stallM),
        .flushD         (flushD),
        .flushE         (flushE),
        .flushW         (flushW),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // {stallF, stallD, stallE, stallM, flushD, flushE, flushW, redirect_valid}
    function automatic logic [7:0] ctl_vec();
        return {stallF, stallD, stallE, stallM, flushD, flushE, flushW, redirect_valid};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle();
        i_req = 0; i_data_ok = 0; d_req = 0; d_data_ok = 0;
        jumpD = 0; branchD = 0; pcsrcD = '0;
        ra1D = 0; ra2D = 0; dstE = 0; dstM = 0;
        memreadE = 0; memreadM = 0;
    endtask

    // Advance to the next falling edge; inputs change there, checks follow #2 later
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #2;
        check("reset_ctl", ctl_vec(), 64'h0E);

        step();
        reset = 1'b1;
        #2 check("idle_ctl", ctl_vec(), 64'h00);

        // Load-use: one cycle of stall with an E bubble
        step();
        memreadE = 1; dstE = 5; ra1D = 5;
        #2 check("lu_ctl", ctl_vec(), 64'hC4);
        step();
        memreadE = 0;
        #2 check("lu_clear", ctl_vec(), 64'h00);
        step();
        memreadE = 1; dstE = 0; ra1D = 0; ra2D = 0;
        #2 check("lu_x0", ctl_vec(), 64'h00);

        // Immediate redirect when the fetch returns in the same cycle
        step();
        idle();
        jumpD = 1; pcsrcD = 64'h8000_0040; i_req = 1; i_data_ok = 1;
        #2 check("imm_ctl", ctl_vec(), 64'h09);
        check("imm_pc", redirect_pc, 64'h8000_0040);
        step();
        idle();
        i_req = 1; pcsrcD = 64'h1234;
        #2 check("imm_iwait_ctl", ctl_vec(), 64'h88);
        check("imm_still_run", redirect_pc, 64'h1234);

        // Kill in-flight fetch
        step();
        idle();
        jumpD = 1; pcsrcD = 64'h100; i_req = 1;
        #2 check("kill_enter_ctl", ctl_vec(), 64'h88);
        for (int c = 0; c < 3; c++) begin
            step();
            jumpD = 1; pcsrcD = 64'h200; i_req = 1; i_data_ok = 0;
            #2 check($sformatf("kill_hold_ctl%0d", c), ctl_vec(), 64'h88);
            check($sformatf("kill_hold_pc%0d", c), redirect_pc, 64'h100);
        end
        step();
        i_data_ok = 1;
        #2 check("kill_ret_ctl", ctl_vec(), 64'h89);
        check("kill_ret_pc", redirect_pc, 64'h100);
        step();
        idle();
        pcsrcD = 64'h300;
        #2 check("kill_back_ctl", ctl_vec(), 64'h00);
        check("kill_back_pc", redirect_pc, 64'h300);

        // Data wait suppresses the jump until the response arrives
        step();
        d_req = 1; jumpD = 1; pcsrcD = 64'h400;
        for (int c = 0; c < 4; c++) begin
            #2 check($sformatf("dwait_ctl%0d", c), ctl_vec(), 64'hF2);
            step();
        end
        d_data_ok = 1;
        #2 check("dwait_done_ctl", ctl_vec(), 64'h09);
        check("dwait_done_pc", redirect_pc, 64'h400);

        // Branch-on-load
        step();
        idle();
        memreadM = 1; dstM = 7; branchD = 1; ra2D = 7; jumpD = 1; pcsrcD = 64'h500;
        #2 check("bl_ctl", ctl_vec(), 64'hC4);
        step();
        memreadM = 0;
        #2 check("bl_done_ctl", ctl_vec(), 64'h09);
        check("bl_done_pc", redirect_pc, 64'h500);
        step();
        memreadM = 1; branchD = 0;
        #2 check("bl_nobranch_ctl", ctl_vec(), 64'h09);

        // Fetch return under dwait while in F_KILL
        step();
        idle();
        jumpD = 1; pcsrcD = 64'h540; i_req = 1;
        #2 check("kd_enter_ctl", ctl_vec(), 64'h88);
        step();
        idle();
        d_req = 1; i_data_ok = 1; pcsrcD = 64'h999;
        #2 check("kd_ctl", ctl_vec(), 64'hFB);
        check("kd_pc", redirect_pc, 64'h540);
        step();
        idle();
        #2 check("kd_back_ctl", ctl_vec(), 64'h00);

        // Asynchronous reset mid-F_KILL, released before the next edge
        step();
        jumpD = 1; pcsrcD = 64'h600; i_req = 1;
        step();
        idle();
        i_req = 1;
        #2 check("ar_kill_ctl", ctl_vec(), 64'h88);
        reset = 1'b0;
        #1 check("ar_ctl", ctl_vec(), 64'h0E);
        #1 reset = 1'b1;
        i_data_ok = 1; pcsrcD = 64'h700;
        #1 check("ar_no_stale_ctl", ctl_vec(), 64'h00);
        check("ar_no_stale_pc", redirect_pc, 64'h700);
        step();
        #2 check("ar_after_edge_ctl", ctl_vec(), 64'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline controller for the five-stage RV64 core. It sequences the F/D/E/M/W pipeline registers by generating per-stage stall and flush controls from four sources:

- load-use hazards against the decode stage;
- branch/jump redirects resolved in decode;
- outstanding instruction-fetch handshakes;
- outstanding data-memory handshakes.

It holds a pending redirect target when a taken jump resolves while a wrong-path fetch is still in flight, and kills that fetch when it returns.

## Interface
Parameters:
- none (widths come from `common`: `u64`, `creg_addr_t`).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request valid this cycle.
- i_data_ok  in  1  fetch response returns this cycle.
- d_req  in  1  M-stage load/store request valid.
- d_data_ok  in  1  data response returns this cycle.
- jumpD  in  1  decode resolved a taken branch/JAL/JALR.
- pcsrcD  in  64  decode target PC.
- branchD  in  1  decode instruction is a branch/JALR (uses operands in D).
- ra1D, ra2D  in  5  decode source registers.
- memreadE, memreadM  in  1  E/M instruction is a load.
- dstE, dstM  in  5  E/M destination registers.
- stallF, stallD, stallE, stallM  out  1  hold that stage's pipeline register.
- flushD, flushE, flushW  out  1  load a bubble into that stage's register at this edge.
- redirect_valid  out  1  fetch PC loads redirect_pc at this edge; overrides stallF.
- redirect_pc  out  64  redirect target.

## Operation
State: `fstate` ∈ {F_RUN, F_KILL}, plus a 64-bit `target` register.

Hazard terms:
- **dwait** = d_req & !d_data_ok.
- **lu** (load-use) = memreadE & dstE≠0 & (dstE==ra1D | dstE==ra2D).
- **bl** (branch-on-load) = branchD & memreadM & dstM≠0 & (dstM==ra1D | dstM==ra2D).
- **iwait** = i_req & !i_data_ok.
- **take** = jumpD & !dwait & !lu & !bl (jumps computed on stale operands are ignored).

Priority, highest first:
- **dwait:** stallF = stallD = stallE = stallM = 1, flushW = 1.
- **lu | bl:** stallF = stallD = 1, flushE = 1.
- Otherwise, in F_RUN:
  - take & !iwait: redirect_valid = 1, redirect_pc = pcsrcD, flushD = 1.
  - take & iwait: latch target ← pcsrcD, go to F_KILL, flushD = 1, stallF = 1.
  - iwait (no take): stallF = 1, flushD = 1.
- In F_KILL, every cycle:
  - flushD = 1 and stallF = 1.
  - On i_data_ok: discard the returned word; redirect_valid = 1 and redirect_pc = target; go to F_RUN.
  - This applies even under dwait: the PC update proceeds while the D–M stalls hold.
  - jumpD is ignored in F_KILL; D holds only bubbles.

Outputs not driven by the rules above are 0. redirect_pc = pcsrcD in F_RUN and target in F_KILL.

## Timing
- All stall, flush and redirect outputs are combinational from inputs and current state, with zero-cycle latency.
- fstate and target update on the rising clk edge.
- The redirect penalty is one bubble with no fetch wait. With an outstanding fetch it is one bubble plus the fetch wait cycles.
- A load-use hazard costs exactly one bubble in E. A branch-on-load costs bubbles until the load leaves M, including any dwait cycles.
- Simultaneous events:
  - take & i_data_ok in the same cycle: immediate redirect, with no F_KILL entry.
  - dwait & take: take is suppressed; jumpD is re-evaluated when dwait clears, because D is held.
- Reset asserted (reset = 0), immediately and asynchronously:
  - fstate = F_RUN, target = 0.
  - All stalls = 0, redirect_valid = 0.
  - flushD = flushE = flushW = 1.
- Reset asserted mid-F_KILL abandons the pending target.

## Structure
- `pipes` package gains:
  - `typedef enum logic [0:0] {F_RUN, F_KILL} fstate_t`;
  - `hazard_ctl_t`, a struct of the stall/flush bits, exported as one bundle to core.
- Sub-module `hazard_detect`: combinational lu/bl comparators. The FSM and priority logic stay in `hazard_ctrl`.

## Test plan
- **Load-use:** E = `ld x5` (memreadE = 1, dstE = 5), D reads ra1D = 5 → stallF = stallD = flushE = 1 for exactly one cycle, then all 0.
- **Immediate redirect:** jumpD = 1, pcsrcD = 0x8000_0040, i_req = 1, i_data_ok = 1 → same cycle redirect_valid = 1, redirect_pc = 0x8000_0040, flushD = 1, fstate stays F_RUN.
- **Kill in-flight fetch:** jumpD = 1, pcsrcD = 0x100, i_data_ok = 0 → F_KILL. Hold i_data_ok = 0 for 3 cycles with flushD = stallF = 1 and jumpD = 1 presented with pcsrcD = 0x200 → jumpD ignored. Then i_data_ok = 1 → redirect_pc = 0x100, back to F_RUN.
- **dmem wait vs jump:** d_req = 1, d_data_ok = 0 for 4 cycles, jumpD = 1 → stallF/D/E/M = 1, flushW = 1, redirect_valid = 0. On the cycle d_data_ok = 1 → redirect taken.
- **Branch-on-load:** memreadM = 1, dstM = 7, branchD = 1, ra2D = 7, jumpD = 1 → no redirect, stallD = 1, flushE = 1; the redirect fires once M advances.
- **Async reset:** drop reset mid-F_KILL, between clk edges → fstate = F_RUN, all stalls 0, flushes 1 immediately. After release, no stale redirect occurs.
